// File: rtl/div_seq_ctrl_if.sv
// Handshake and data bundle between the EX stage and the divide sequencer.
// The master side is EX: it offers the request and operands, flushes with
// cancel and drains the result with out_ready. The slave side is the sequencer.
interface div_seq_ctrl_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      div_op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            cancel;
  logic            busy;
  logic            done;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output req_valid, div_op, src1, src2, cancel, out_ready,
    input  req_ready, busy, done, result
  );

  modport slave (
    input  req_valid, div_op, src1, src2, cancel, out_ready,
    output req_ready, busy, done, result
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequencer for the EX-stage iterative 32-bit divider.
// Operands are reduced to magnitudes at accept, a 32-step restoring
// shift-subtract produces quotient and remainder, and one fix-up cycle
// applies the signs (or the divide-by-zero results) before the result is
// held until EX hands the instruction to MEM.
module div_seq_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  div_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] quot_reg;
  logic [XLEN-1:0] dvs_reg;      // |src2|
  logic            s1_reg;       // dividend was negative (signed ops only)
  logic            s2_reg;       // divisor was negative (signed ops only)
  logic            want_rem_reg;
  logic            dvz_reg;      // divisor was zero
  logic [XLEN-1:0] result_reg;

  // Operand preparation for the accept cycle
  logic            op_signed;
  logic            neg1, neg2;
  logic [XLEN-1:0] abs1, abs2;
  logic            src2_zero;

  assign op_signed = ~bus.div_op[1];
  assign neg1      = op_signed & bus.src1[XLEN-1];
  assign neg2      = op_signed & bus.src2[XLEN-1];
  assign abs1      = neg1 ? (~bus.src1 + 1'b1) : bus.src1;
  assign abs2      = neg2 ? (~bus.src2 + 1'b1) : bus.src2;
  assign src2_zero = (bus.src2 == '0);

  // One restoring step: the partial remainder is always below the divisor
  // magnitude, so the shifted value fits in XLEN+1 bits and bit XLEN of the
  // difference is its sign.
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   trial;
  logic            trial_ok;

  assign rem_shift = {rem_reg, quot_reg[XLEN-1]};
  assign trial     = rem_shift - {1'b0, dvs_reg};
  assign trial_ok  = ~trial[XLEN];

  // Sign fix-up of the magnitude results
  logic [XLEN-1:0] fix_val;

  always_comb begin
    fix_val = quot_reg;
    if (want_rem_reg)
      fix_val = s1_reg ? (~rem_reg + 1'b1) : rem_reg;
    else if (dvz_reg)
      fix_val = '1;
    else
      fix_val = (s1_reg ^ s2_reg) ? (~quot_reg + 1'b1) : quot_reg;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic; cancel overrides every normal transition
  always_comb begin
    state_next = state_reg;
    if (bus.cancel) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: if (bus.req_valid) state_next = src2_zero ? S_FIX : S_ITER;
        S_ITER: if (cnt_reg == CNT_W'(XLEN-1)) state_next = S_FIX;
        S_FIX:  state_next = S_DONE;
        S_DONE: if (bus.out_ready) state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Datapath: latch operands at accept, iterate, and form the result in FIX
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg      <= '0;
      rem_reg      <= '0;
      quot_reg     <= '0;
      dvs_reg      <= '0;
      s1_reg       <= 1'b0;
      s2_reg       <= 1'b0;
      want_rem_reg <= 1'b0;
      dvz_reg      <= 1'b0;
      result_reg   <= '0;
    end else if (!bus.cancel) begin
      case (state_reg)
        S_IDLE: begin
          if (bus.req_valid) begin
            cnt_reg      <= '0;
            quot_reg     <= abs1;
            dvs_reg      <= abs2;
            s1_reg       <= neg1;
            s2_reg       <= neg2;
            want_rem_reg <= bus.div_op[0];
            dvz_reg      <= src2_zero;
            // With a zero divisor the iteration is skipped; parking |src1|
            // in the remainder lets the normal sign fix-up reproduce src1.
            rem_reg      <= src2_zero ? abs1 : '0;
          end
        end
        S_ITER: begin
          rem_reg  <= trial_ok ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
          quot_reg <= {quot_reg[XLEN-2:0], trial_ok};
          cnt_reg  <= cnt_reg + CNT_W'(1);
        end
        S_FIX: begin
          result_reg <= fix_val;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state_reg == S_ITER) | (state_reg == S_FIX);
  assign bus.done      = (state_reg == S_DONE);
  assign bus.req_ready = (state_reg == S_IDLE);
  assign bus.result    = result_reg;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed vector table, randomized
// operations against an arithmetic reference, and hand-written sequences for
// cancel, result hold / bubble, and reset during iteration.
module tb_div_seq_ctrl;

  logic clk;
  logic reset;

  div_seq_ctrl_if bus ();

  div_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero and
  // the remainder follows the dividend's sign.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return op[0] ? a : 32'hFFFF_FFFF;
    if (!op[1]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return op[0] ? r[31:0] : q[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns just after the accept edge.
  task automatic start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1'b1;
    bus.div_op    = op;
    bus.src1      = a;
    bus.src2      = b;
    tick();
    bus.req_valid = 1'b0;
    // Scramble operands: the DUT must have latched them
    bus.div_op    = 2'($urandom);
    bus.src1      = $urandom;
    bus.src2      = $urandom;
  endtask

  // Poll for done; lat is the cycle index relative to the accept cycle T.
  task automatic wait_done(output logic [31:0] res, output int lat);
    lat = 1;
    while (!bus.done && lat < 100) begin
      tick();
      lat++;
    end
    res = bus.result;
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("drain_req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int lat;
    start(op, a, b);
    wait_done(res, lat);
    $display("%s op=%0d src1=%h src2=%h result=%h lat=T+%0d", tag, op, a, b, res, lat);
    chk({tag, "_result"}, res, exp);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    drain();
  endtask

  initial begin
    logic [31:0] res, a, b;
    logic [1:0]  op;
    int lat;

    vecs[0]  = '{2'b00, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
    vecs[1]  = '{2'b01, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vecs[2]  = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 34};
    vecs[3]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 34};
    vecs[4]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34};
    vecs[5]  = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34};
    vecs[6]  = '{2'b00, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF, 2};
    vecs[7]  = '{2'b01, 32'h8765_4321, 32'h0000_0000, 32'h8765_4321, 2};
    vecs[8]  = '{2'b10, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 2};
    vecs[9]  = '{2'b11, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 2};
    vecs[10] = '{2'b00, 32'd100,       32'd7,         32'd14,        34};
    vecs[11] = '{2'b01, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, 34};
    vecs[12] = '{2'b00, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};

    bus.req_valid = 1'b0;
    bus.div_op    = 2'b00;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.cancel    = 1'b0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    tick();
    tick();
    chk("reset_busy",      32'(bus.busy),      32'd0);
    chk("reset_done",      32'(bus.done),      32'd0);
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_result",    bus.result,         32'h0);
    reset = 1'b0;
    tick();

    // Directed vectors
    for (int i = 0; i < NVEC; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'h0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        3: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      run_op($sformatf("rnd%0d", i), op, a, b, ref_div(op, a, b), (b == 0) ? 2 : 34);
    end

    // Cancel in IDLE: offered request is not accepted
    bus.req_valid = 1'b1;
    bus.cancel    = 1'b1;
    bus.div_op    = 2'b00;
    bus.src1      = 32'd100;
    bus.src2      = 32'd7;
    tick();
    bus.req_valid = 1'b0;
    bus.cancel    = 1'b0;
    chk("idle_cancel_busy",      32'(bus.busy),      32'd0);
    chk("idle_cancel_req_ready", 32'(bus.req_ready), 32'd1);
    $display("idle_cancel busy=%0d req_ready=%0d", bus.busy, bus.req_ready);

    // Cancel at T+10 of div.w 100/7; next request accepted at T+11
    start(2'b00, 32'd100, 32'd7);
    for (int c = 1; c < 10; c++) tick();
    chk("cancel_busy_before", 32'(bus.busy), 32'd1);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    chk("cancel_req_ready", 32'(bus.req_ready), 32'd1);
    chk("cancel_busy",      32'(bus.busy),      32'd0);
    chk("cancel_done",      32'(bus.done),      32'd0);
    $display("cancel at T+10 -> req_ready=%0d busy=%0d done=%0d", bus.req_ready, bus.busy, bus.done);
    run_op("after_cancel", 2'b11, 32'd1000, 32'd33, 32'd10, 34);

    // Hold with out_ready low, then release with a 1-cycle bubble
    start(2'b00, 32'd100, 32'd7);
    wait_done(res, lat);
    chk("hold_latency", 32'(lat), 32'd34);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("hold_done",   32'(bus.done), 32'd1);
      chk("hold_result", bus.result,    32'd14);
    end
    bus.req_valid = 1'b1;
    bus.div_op    = 2'b10;
    bus.src1      = 32'd99;
    bus.src2      = 32'd10;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("bubble_done",      32'(bus.done),      32'd0);
    chk("bubble_busy",      32'(bus.busy),      32'd0);
    chk("bubble_req_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("bubble_accept_busy", 32'(bus.busy), 32'd1);
    wait_done(res, lat);
    $display("hold/bubble op=2 src1=99 src2=10 result=%h lat=T+%0d", res, lat);
    chk("bubble_result",  res,        32'd9);
    chk("bubble_latency", 32'(lat),   32'd34);
    drain();

    // Reset at T+20 mid-iteration, then a fresh op
    start(2'b00, 32'd100, 32'd7);
    for (int c = 1; c < 20; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midreset_busy",      32'(bus.busy),      32'd0);
    chk("midreset_done",      32'(bus.done),      32'd0);
    chk("midreset_req_ready", 32'(bus.req_ready), 32'd1);
    $display("reset at T+20 -> busy=%0d done=%0d req_ready=%0d", bus.busy, bus.done, bus.req_ready);
    run_op("after_reset", 2'b01, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
